// File: rtl/neuron_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : neuron_pkg                                                       |
// | Purpose : Shared types and helpers for the neuron weight sequencer.        |
// |           Holds the sequencer state encoding and the address-range check   |
// |           used at elaboration time.                                        |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package neuron_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } seq_state_t;

  // Largest address width the range check below can evaluate safely.
  localparam int unsigned MAX_ADDRESS_BITS = 31;

  // True when n weights (n >= 1) fit in an address space of 'bits' bits.
  function automatic bit addr_range_ok(input int unsigned n, input int unsigned bits);
    return (bits >= 1) && (bits <= MAX_ADDRESS_BITS) && (n >= 1) &&
           (longint'(n) <= (longint'(1) << bits));
  endfunction

endpackage : neuron_pkg
`default_nettype wire

// File: rtl/seq_addr_counter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : seq_addr_counter                                                 |
// | Purpose : Weight-memory address counter shared by the LOAD and RUN modes.  |
// |           Counts 0..LAST and returns to 0 on the increment at LAST, so it  |
// |           never produces an address beyond the last weight.                |
// | Ports   : clk_i    rising-edge clock                                       |
// |           rst_ni   asynchronous active-low reset                           |
// |           clear_i  force count to 0 (priority over inc_i)                  |
// |           inc_i    advance count by one                                    |
// |           count_o  current address                                         |
// |           tc_o     terminal count flag (count_o == LAST)                   |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module seq_addr_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned LAST  = 783
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o,
  output logic             tc_o
);

  localparam logic [WIDTH-1:0] LAST_VAL = WIDTH'(LAST);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  assign tc_o    = (count_q == LAST_VAL);
  assign count_o = count_q;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (inc_i) begin
      count_d = tc_o ? '0 : count_q + WIDTH'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule : seq_addr_counter
`default_nettype wire

// File: rtl/weight_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : weight_sequencer                                                 |
// | Purpose : Controller in front of one neuron's weight memory. LOAD mode     |
// |           streams NUM_WEIGHTS weights into addresses 0..N-1; RUN mode      |
// |           reads one weight per accepted activation and hands the aligned   |
// |           {weight, activation} pair to the MAC stage one cycle later.      |
// | Ports   : clk_i / reset_ni          clock, async active-low reset          |
// |           load_start_i/run_start_i  mode start pulses (IDLE only)          |
// |           abort_i                   return to IDLE, no done pulse          |
// |           w_valid_i/w_data_i/w_ready_o   weight stream                     |
// |           x_valid_i/x_data_i/x_ready_o   activation stream                 |
// |           mem_*                     weight memory write/read ports         |
// |           mac_*                     pair to MAC (no backpressure)          |
// |           busy_o/load_done_o/run_done_o  status                            |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module weight_sequencer
  import neuron_pkg::*;
#(
  parameter int unsigned DATA_BITS    = 16,
  parameter int unsigned NUM_WEIGHTS  = 784,
  parameter int unsigned ADDRESS_BITS = 10
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    load_start_i,
  input  logic                    run_start_i,
  input  logic                    abort_i,
  input  logic                    w_valid_i,
  input  logic [DATA_BITS-1:0]    w_data_i,
  output logic                    w_ready_o,
  input  logic                    x_valid_i,
  input  logic [DATA_BITS-1:0]    x_data_i,
  output logic                    x_ready_o,
  output logic                    mem_write_en_o,
  output logic [ADDRESS_BITS-1:0] mem_write_add_o,
  output logic [DATA_BITS-1:0]    mem_weight_in_o,
  output logic                    mem_read_en_o,
  output logic [ADDRESS_BITS-1:0] mem_read_add_o,
  input  logic [DATA_BITS-1:0]    mem_weight_out_i,
  output logic                    mac_valid_o,
  output logic [DATA_BITS-1:0]    mac_weight_o,
  output logic [DATA_BITS-1:0]    mac_x_o,
  output logic                    mac_last_o,
  output logic                    busy_o,
  output logic                    load_done_o,
  output logic                    run_done_o
);

  generate
    if (!addr_range_ok(NUM_WEIGHTS, ADDRESS_BITS)) begin : g_param_check
      $error("weight_sequencer: NUM_WEIGHTS must be in 1..2**ADDRESS_BITS");
    end
  endgenerate

  seq_state_t              state_q;
  seq_state_t              state_d;
  logic [ADDRESS_BITS-1:0] cnt;
  logic                    cnt_tc;
  logic                    cnt_clear;
  logic                    cnt_inc;
  logic                    w_accept;
  logic                    x_accept;
  logic [DATA_BITS-1:0]    x_q;
  logic                    pair_q;
  logic                    load_done_q;

  // Handshake qualification. Ready is withdrawn while abort is high so a beat
  // offered in the abort cycle (including the final one) is never consumed.
  assign w_accept = w_valid_i && (state_q == LOAD) && !abort_i;
  assign x_accept = x_valid_i && (state_q == RUN)  && !abort_i;

  // Counter sits at 0 whenever idle; abort also rewinds it so the next pass
  // always starts at address 0.
  assign cnt_clear = (state_q == IDLE) || abort_i;
  assign cnt_inc   = w_accept || x_accept;

  seq_addr_counter #(
    .WIDTH (ADDRESS_BITS),
    .LAST  (NUM_WEIGHTS - 1)
  ) u_addr_counter (
    .clk_i   (clk_i),
    .rst_ni  (reset_ni),
    .clear_i (cnt_clear),
    .inc_i   (cnt_inc),
    .count_o (cnt),
    .tc_o    (cnt_tc)
  );

  // State register
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        // load_start has priority; a coincident run_start is dropped.
        if (load_start_i) begin
          state_d = LOAD;
        end else if (run_start_i) begin
          state_d = RUN;
        end
      end
      LOAD: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (w_accept && cnt_tc) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (abort_i) begin
          state_d = IDLE;
        end else if (x_accept && cnt_tc) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath registers: the activation is held one cycle so it lines up with
  // the registered memory read; pair_q marks that a read was issued last cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      x_q         <= '0;
      pair_q      <= 1'b0;
      load_done_q <= 1'b0;
    end else begin
      pair_q      <= x_accept;
      load_done_q <= w_accept && cnt_tc;
      if (x_accept) begin
        x_q <= x_data_i;
      end
    end
  end

  // Output logic. Address/data buses are forced to 0 when not strobed so that
  // every output reads 0 while reset is held.
  always_comb begin
    w_ready_o       = (state_q == LOAD) && !abort_i;
    x_ready_o       = (state_q == RUN)  && !abort_i;
    mem_write_en_o  = w_accept;
    mem_write_add_o = w_accept ? cnt : '0;
    mem_weight_in_o = w_accept ? w_data_i : '0;
    mem_read_en_o   = x_accept;
    mem_read_add_o  = x_accept ? cnt : '0;
    mac_valid_o     = pair_q;
    mac_weight_o    = pair_q ? mem_weight_out_i : '0;
    mac_x_o         = pair_q ? x_q : '0;
    // DRAIN is exactly the cycle in which the final pair is presented.
    mac_last_o      = (state_q == DRAIN);
    run_done_o      = (state_q == DRAIN);
    busy_o          = (state_q != IDLE);
    load_done_o     = load_done_q;
  end

endmodule : weight_sequencer
`default_nettype wire

// File: tb/tb_weight_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_weight_sequencer                                              |
// | Purpose : Directed self-checking bench for weight_sequencer (N=8, 4-bit    |
// |           addresses) paired with a 1-cycle registered weight memory model. |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_weight_sequencer;

  localparam int unsigned DW = 16;
  localparam int unsigned N  = 8;
  localparam int unsigned AW = 4;

  logic          clk;
  logic          reset_n;
  logic          load_start, run_start, abort;
  logic          w_valid, w_ready;
  logic [DW-1:0] w_data;
  logic          x_valid, x_ready;
  logic [DW-1:0] x_data;
  logic          mem_write_en, mem_read_en;
  logic [AW-1:0] mem_write_add, mem_read_add;
  logic [DW-1:0] mem_weight_in, mem_weight_out;
  logic          mac_valid, mac_last;
  logic [DW-1:0] mac_weight, mac_x;
  logic          busy, load_done, run_done;

  int errors = 0;
  int checks = 0;

  weight_sequencer #(
    .DATA_BITS    (DW),
    .NUM_WEIGHTS  (N),
    .ADDRESS_BITS (AW)
  ) dut (
    .clk_i            (clk),
    .reset_ni         (reset_n),
    .load_start_i     (load_start),
    .run_start_i      (run_start),
    .abort_i          (abort),
    .w_valid_i        (w_valid),
    .w_data_i         (w_data),
    .w_ready_o        (w_ready),
    .x_valid_i        (x_valid),
    .x_data_i         (x_data),
    .x_ready_o        (x_ready),
    .mem_write_en_o   (mem_write_en),
    .mem_write_add_o  (mem_write_add),
    .mem_weight_in_o  (mem_weight_in),
    .mem_read_en_o    (mem_read_en),
    .mem_read_add_o   (mem_read_add),
    .mem_weight_out_i (mem_weight_out),
    .mac_valid_o      (mac_valid),
    .mac_weight_o     (mac_weight),
    .mac_x_o          (mac_x),
    .mac_last_o       (mac_last),
    .busy_o           (busy),
    .load_done_o      (load_done),
    .run_done_o       (run_done)
  );

  // Weight memory model: synchronous write, 1-cycle registered read.
  logic [DW-1:0] mem [1<<AW];
  always @(posedge clk) begin
    if (mem_write_en) mem[mem_write_add] <= mem_weight_in;
    if (mem_read_en)  mem_weight_out     <= mem[mem_read_add];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; load_start = 1'b0; run_start = 1'b0; abort = 1'b0;
    w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0;

    // ---------------- reset state ----------------
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_w_ready", w_ready, 0);
    chk("rst_x_ready", x_ready, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_re", mem_read_en, 0);
    chk("rst_mac_valid", mac_valid, 0);
    chk("rst_done", {load_done, run_done, mac_last}, 0);
    tick(); tick();
    reset_n = 1'b1;

    // ---------------- load 0x0010..0x0017, run_start ignored mid-load ----------------
    load_start = 1'b1;
    #2;
    chk("idle_w_ready", w_ready, 0);
    tick();
    load_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      w_valid   = 1'b1;
      w_data    = 16'h0010 + 16'(i);
      run_start = (i == 3);
      #2;
      chk("load_we", mem_write_en, 1);
      chk("load_addr", mem_write_add, i);
      chk("load_data", mem_weight_in, 32'h10 + i);
      chk("load_rdy", {w_ready, x_ready, busy, mem_read_en}, 4'b1010);
      tick();
    end
    w_valid = 1'b0; run_start = 1'b0;
    #2;
    chk("load_done_pulse", load_done, 1);
    chk("load_busy_drop", busy, 0);
    chk("load_we_after", mem_write_en, 0);
    tick();
    chk("load_done_once", load_done, 0);

    // ---------------- run x=1..8 continuous ----------------
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      x_valid = 1'b1;
      x_data  = 16'(i + 1);
      #2;
      chk("run_x_ready", x_ready, 1);
      chk("run_re", {mem_read_en, mem_write_en}, 2'b10);
      chk("run_raddr", mem_read_add, i);
      if (i == 0) begin
        chk("run_first_no_mac", mac_valid, 0);
      end else begin
        chk("run_mac", {mac_valid, mac_last, run_done}, 3'b100);
        chk("run_mac_w", mac_weight, 32'h10 + i - 1);
        chk("run_mac_x", mac_x, i);
      end
      tick();
    end
    x_valid = 1'b0;
    #2;
    chk("drain_flags", {mac_valid, mac_last, run_done, x_ready}, 4'b1110);
    chk("drain_w", mac_weight, 32'h17);
    chk("drain_x", mac_x, 8);
    tick();
    chk("post_run", {busy, mac_valid, run_done, mac_last}, 0);

    // ---------------- run with x_valid gaps ----------------
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int c = 0; c < 16; c++) begin
      x_valid = (c % 2 == 0);
      x_data  = 16'h0100 + 16'(c);
      #2;
      if (c % 2 == 0) begin
        chk("gap_re", mem_read_en, 1);
        chk("gap_raddr", mem_read_add, c / 2);
        chk("gap_no_mac", mac_valid, 0);
      end else begin
        chk("gap_re_idle", mem_read_en, 0);
        chk("gap_mac", {mac_valid, mac_last}, {1'b1, (c == 15)});
        chk("gap_mac_w", mac_weight, 32'h10 + (c - 1) / 2);
        chk("gap_mac_x", mac_x, 32'h100 + c - 1);
      end
      tick();
    end
    x_valid = 1'b0;
    #2;
    chk("gap_end_idle", busy, 0);

    // ---------------- start collision, then abort in LOAD ----------------
    load_start = 1'b1; run_start = 1'b1;
    tick();
    load_start = 1'b0; run_start = 1'b0;
    #2;
    chk("coll_ready", {w_ready, x_ready, busy}, 3'b101);
    abort = 1'b1; w_valid = 1'b1; w_data = 16'hBEEF;
    #1;
    chk("abort_load_blocks", {w_ready, mem_write_en}, 0);
    tick();
    abort = 1'b0; w_valid = 1'b0;
    #2;
    chk("abort_load_idle", {busy, load_done}, 0);

    // ---------------- abort after 3 run beats ----------------
    run_start = 1'b1;
    tick();
    run_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      x_valid = 1'b1;
      x_data  = 16'h0020 + 16'(i);
      #2;
      chk("abr_raddr", mem_read_add, i);
      tick();
    end
    abort = 1'b1;
    #2;
    chk("abr_blocks", {x_ready, mem_read_en}, 0);
    chk("abr_pair", {mac_valid, mac_last, run_done}, 3'b100);
    chk("abr_pair_w", mac_weight, 32'h12);
    chk("abr_pair_x", mac_x, 32'h22);
    tick();
    abort = 1'b0; x_valid = 1'b0;
    #2;
    chk("abr_idle", {busy, mac_valid, run_done}, 0);
    run_start = 1'b1;
    tick();
    run_start = 1'b0; x_valid = 1'b1; x_data = 16'h0005;
    #2;
    chk("abr_restart_addr", {mem_read_en, 4'(mem_read_add)}, 5'b10000);
    tick();
    x_valid = 1'b0; abort = 1'b1;
    tick();
    abort = 1'b0;

    // ---------------- async reset mid-LOAD ----------------
    load_start = 1'b1;
    tick();
    load_start = 1'b0; w_valid = 1'b1; w_data = 16'h0055;
    tick();
    #2;
    chk("mid_load_addr", mem_write_add, 1);
    reset_n = 1'b0;
    #1;
    chk("arst_ctrl", {busy, w_ready, mem_write_en, load_done}, 0);
    chk("arst_bus", {4'(mem_write_add), mem_weight_in}, 0);
    w_valid = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    #2;
    chk("arst_release_idle", busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_weight_sequencer
`default_nettype wire
